idecode_hz: RTL
===============

// Module: idecode_hz
// PURPOSE
//  Parametrised bexkat1 decode stage; successor to the fixed 32-bit decode stage.
//  Contains the register file and latches IR/PC/operands into the ID/EX register.
//  Adds a valid bit, flush, load-use hazard detection with bubble insertion,
//  half-word write enables, and operand refresh while the stage is held.
//  Sits between ifetch and execute.
// PARAMETERS
//  DATA_W  32  register/operand width; multiple of 16; WE_W = DATA_W/16
//  IR_W    64  instruction width; fields at [31:0]: type[31:28] ra[23:20] rb[19:16] rc[15:12]
//  PC_W    32  program counter width
//  NREG    16  register count, 2..16; reads of index >= NREG return 0, writes ignored
// PORTS
//  clk_i         in   1       clock
//  rst_ni        in   1       async reset, active low
//  ir_i          in   IR_W    instruction from fetch
//  pc_i          in   PC_W    PC of ir_i
//  valid_i       in   1       ir_i/pc_i valid
//  stall_i       in   1       downstream hold
//  flush_i       in   1       kill instruction entering ID/EX (branch taken)
//  ex_load_i     in   1       instruction in EX is a load
//  ex_dest_i     in   4       load destination register
//  wb_we_i       in   WE_W    writeback 16-bit-lane enables (bit k -> [16k+15:16k])
//  wb_addr_i     in   4       writeback register
//  wb_data_i     in   DATA_W  writeback data
//  stall_o       out  1       upstream hold
//  valid_o       out  1       ID/EX valid
//  ir_o          out  IR_W    ID/EX instruction
//  pc_o          out  PC_W    ID/EX PC
//  src1_o        out  4       source 1 index of held instruction
//  src2_o        out  4       source 2 index of held instruction
//  data1_o       out  DATA_W  operand 1
//  data2_o       out  DATA_W  operand 2
// BEHAVIOUR
//  - Reset (rst_ni=0, async): every output and register-file entry = 0.
//  - Source select: src1=rb, src2=rc; when type==T_CMP (bexkat1Def), src1=ra, src2=rb.
//  - Write: mem[wb_addr_i] <= (mem & ~M) | (wb_data_i & M), M = lanes from wb_we_i.
//    Committed at posedge; wb_we_i==0 means no write.
//  - ldhaz = valid_i & ex_load_i & (ex_dest_i==src1 | ex_dest_i==src2).
//  - wrhaz = write-conflict term (see CONFIGURATION); hz = ldhaz | wrhaz.
//  - stall_o = stall_i | (hz & ~flush_i); combinational, no state.
//  - Per-cycle priority:
//    1 flush_i: valid_o<=0, ir_o<=0, pc_o<=0, src/data<=0.
//    2 stall_i: ID/EX fields held. If a write hits src1_o (or src2_o),
//      data1_o (data2_o) <= merged value (refresh). Both refresh when src1_o==src2_o.
//    3 hz: bubble. valid_o<=0, ir_o<=0, pc_o<=0. Upstream holds via stall_o.
//    4 else: valid_o<=valid_i, ir_o<=ir_i, pc_o<=pc_i, src<=src1/2, data<=regfile read.
//  - Latency: 1 cycle from ir_i to ir_o. A load-use costs exactly 1 bubble per
//    ex_load_i cycle.
//  - An invalid ir_i (valid_i=0) never raises hz. It still advances, with valid_o=0.
//  - Reset mid-stall drops the held instruction. No residual stall after reset.
// CONFIGURATION
//  IDECODE_BYPASS_EN defined:
//    - In case 4, a same-cycle write to src1/src2 is forwarded.
//    - data*_o captures the merged value; wrhaz = 0.
//  Undefined:
//    - wrhaz = valid_i & (wb_we_i!=0) & (wb_addr_i==src1 | wb_addr_i==src2).
//    - Costs one bubble; the instruction re-reads the committed value next cycle.
//  Stall-time refresh (case 2) is present in both builds.
// TESTING
//  1 Reset: rst_ni=0 mid-run -> all outputs 0 immediately.
//    Then read r1,r2 -> data 0.
//  2 Write r3=32'hDEADBEEF (we=2'b11), then r3 we=2'b01 data 32'h00001234
//    -> later read of r3 gives 32'hDEAD1234.
//  3 ex_load_i=1, ex_dest_i=4, ir_i rb=4 -> stall_o=1, next valid_o=0.
//    Next cycle (load gone) instr issues with r4 value.
//  4 stall_i held 3 cycles with src1_o=5; wb r5=32'h55 in cycle 2
//    -> data1_o=32'h55 after release, ir_o unchanged.
//  5 flush_i with stall_i=1 and valid_i=1 -> valid_o=0, ir_o=0 next cycle.
//  6 Write r6=32'h66 same cycle as read of r6:
//    bypass build -> data1_o=32'h66, no stall.
//    Non-bypass build -> 1 bubble, then data1_o=32'h66.

Source files
------------

// File: rtl/idecode_hz.sv
// idecode_hz: bexkat1 decode stage with register file, ID/EX register, flush and hazard bubbles
//
// Optional feature macro: IDECODE_BYPASS_EN (same-cycle writeback forwarded into the
// operand read instead of costing a bubble).
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   ir_i, pc_i, valid_i        instruction, PC and valid from fetch
//   stall_i, flush_i           downstream hold, kill of the instruction entering ID/EX
//   ex_load_i, ex_dest_i       load in EX and its destination register
//   wb_we_i, wb_addr_i, wb_data_i  writeback 16-bit lane enables, register, data
//   stall_o                    upstream hold
//   valid_o, ir_o, pc_o        ID/EX valid, instruction, PC
//   src1_o, src2_o             source indices of the held instruction
//   data1_o, data2_o           operands
module idecode_hz #(
    parameter int DATA_W = 32,
    parameter int IR_W   = 64,
    parameter int PC_W   = 32,
    parameter int NREG   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IR_W-1:0]      ir_i,
    input  logic [PC_W-1:0]      pc_i,
    input  logic                 valid_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 ex_load_i,
    input  logic [3:0]           ex_dest_i,
    input  logic [DATA_W/16-1:0] wb_we_i,
    input  logic [3:0]           wb_addr_i,
    input  logic [DATA_W-1:0]    wb_data_i,
    output logic                 stall_o,
    output logic                 valid_o,
    output logic [IR_W-1:0]      ir_o,
    output logic [PC_W-1:0]      pc_o,
    output logic [3:0]           src1_o,
    output logic [3:0]           src2_o,
    output logic [DATA_W-1:0]    data1_o,
    output logic [DATA_W-1:0]    data2_o
);
    localparam int WE_W = DATA_W / 16;
    localparam logic [3:0] T_CMP = 4'h3;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [DATA_W-1:0] lane_m, wr_val, reg1, reg2, rd1, rd2;
    logic [DATA_W-1:0] data1_d, data1_q, data2_d, data2_q;
    logic [IR_W-1:0]   ir_d, ir_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic [3:0]        src1, src2, src1_d, src1_q, src2_d, src2_q;
    logic              valid_d, valid_q, wr_en, ldhaz, wrhaz, hz, is_cmp;

    assign is_cmp = ir_i[31:28] == T_CMP;
    assign src1   = is_cmp ? ir_i[23:20] : ir_i[19:16];
    assign src2   = is_cmp ? ir_i[19:16] : ir_i[15:12];

    // Merged writeback value: untouched lanes keep the committed register contents.
    always_comb begin
        lane_m = '0;
        for (int k = 0; k < WE_W; k++) lane_m[16*k +: 16] = {16{wb_we_i[k]}};
        wr_en  = (wb_we_i != '0) && (32'(wb_addr_i) < NREG);
        wr_val = (((32'(wb_addr_i) < NREG) ? mem_q[wb_addr_i] : '0) & ~lane_m) | (wb_data_i & lane_m);
        reg1   = (32'(src1) < NREG) ? mem_q[src1] : '0;
        reg2   = (32'(src2) < NREG) ? mem_q[src2] : '0;
    end

`ifdef IDECODE_BYPASS_EN
    assign wrhaz = 1'b0;
    assign rd1   = (wr_en && wb_addr_i == src1) ? wr_val : reg1;
    assign rd2   = (wr_en && wb_addr_i == src2) ? wr_val : reg2;
`else
    // Without forwarding a same-cycle write costs a bubble; the re-read sees the committed value.
    assign wrhaz = valid_i & (wb_we_i != '0) & (wb_addr_i == src1 | wb_addr_i == src2);
    assign rd1   = reg1;
    assign rd2   = reg2;
`endif

    assign ldhaz   = valid_i & ex_load_i & (ex_dest_i == src1 | ex_dest_i == src2);
    assign hz      = ldhaz | wrhaz;
    assign stall_o = stall_i | (hz & ~flush_i);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wb_addr_i] = wr_val;
    end

    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ir_d    = '0;
            pc_d    = '0;
            src1_d  = '0;
            src2_d  = '0;
            data1_d = '0;
            data2_d = '0;
        end else if (stall_i) begin
            // Keep held operands coherent with writes that land while the stage waits.
            data1_d = (wr_en && wb_addr_i == src1_q) ? wr_val : data1_q;
            data2_d = (wr_en && wb_addr_i == src2_q) ? wr_val : data2_q;
        end else if (hz) begin
            valid_d = 1'b0;
            ir_d    = '0;
            pc_d    = '0;
        end else begin
            valid_d = valid_i;
            ir_d    = ir_i;
            pc_d    = pc_i;
            src1_d  = src1;
            src2_d  = src2;
            data1_d = rd1;
            data2_d = rd2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign valid_o = valid_q;
    assign ir_o    = ir_q;
    assign pc_o    = pc_q;
    assign src1_o  = src1_q;
    assign src2_o  = src2_q;
    assign data1_o = data1_q;
    assign data2_o = data2_q;
endmodule
